// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI field widths, field typedefs and register-slice enums for the tvip AXI blocks.
package tvip_axi_types_pkg;

   localparam int TVIP_AXI_BURST_LENGTH_WIDTH = 8;
   localparam int TVIP_AXI_BURST_SIZE_WIDTH   = 3;
   localparam int TVIP_AXI_BURST_TYPE_WIDTH   = 2;
   localparam int TVIP_AXI_QOS_WIDTH          = 4;
   localparam int TVIP_AXI_RESPONSE_WIDTH     = 2;

   typedef logic [TVIP_AXI_BURST_LENGTH_WIDTH-1:0] tvip_axi_burst_length;
   typedef logic [TVIP_AXI_BURST_SIZE_WIDTH-1:0]   tvip_axi_burst_size;
   typedef logic [TVIP_AXI_BURST_TYPE_WIDTH-1:0]   tvip_axi_burst_type;
   typedef logic [TVIP_AXI_QOS_WIDTH-1:0]          tvip_axi_qos;
   typedef logic [TVIP_AXI_RESPONSE_WIDTH-1:0]     tvip_axi_response;

   typedef enum logic [1:0] {
      TVIP_AXI_SLICE_BYPASS = 2'd0,
      TVIP_AXI_SLICE_LIGHT  = 2'd1,
      TVIP_AXI_SLICE_FULL   = 2'd2
   } tvip_axi_slice_mode;

   typedef enum logic [1:0] {
      TVIP_AXI_SLICE_EMPTY = 2'd0,
      TVIP_AXI_SLICE_ONE   = 2'd1,
      TVIP_AXI_SLICE_TWO   = 2'd2
   } tvip_axi_slice_state;

   // Address-channel payload: id, addr, len, size, burst, qos.
   function automatic int tvip_axi_addr_payload_width(int id_width, int address_width);
      return id_width + address_width + TVIP_AXI_BURST_LENGTH_WIDTH + TVIP_AXI_BURST_SIZE_WIDTH
           + TVIP_AXI_BURST_TYPE_WIDTH + TVIP_AXI_QOS_WIDTH;
   endfunction

endpackage

// File: rtl/tvip_axi_slice_channel.sv
// One valid/ready register slice: BYPASS (wires), LIGHT (single register) or FULL (main + skid).
module tvip_axi_slice_channel
   import tvip_axi_types_pkg::*;
#(
   parameter int                 WIDTH = 8,
   parameter tvip_axi_slice_mode MODE  = TVIP_AXI_SLICE_FULL
)(
   input  logic             aclk,
   input  logic             areset_n,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_payload,
   output logic             dst_valid,
   input  logic             dst_ready,
   output logic [WIDTH-1:0] dst_payload
);

   generate
      if (MODE == TVIP_AXI_SLICE_BYPASS) begin : g_bypass
         assign dst_valid   = src_valid;
         assign src_ready   = dst_ready;
         assign dst_payload = src_payload;
      end else if (MODE == TVIP_AXI_SLICE_LIGHT) begin : g_light
         logic             r_full;
         logic             r_ready;
         logic [WIDTH-1:0] r_data;
         logic             w_src_hs;
         logic             w_dst_hs;
         logic             w_full_next;

         // Ready only while empty, so load and unload never share a cycle.
         assign w_src_hs    = src_valid && r_ready;
         assign w_dst_hs    = r_full && dst_ready;
         assign w_full_next = w_src_hs || (r_full && !w_dst_hs);

         always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
               r_full  <= 1'b0;
               r_ready <= 1'b0;
               r_data  <= '0;
            end else begin
               r_full  <= w_full_next;
               r_ready <= !w_full_next;
               if (w_src_hs) r_data <= src_payload;
            end
         end

         assign src_ready   = r_ready;
         assign dst_valid   = r_full;
         assign dst_payload = r_data;
      end else begin : g_full
         tvip_axi_slice_state r_state;
         tvip_axi_slice_state w_state_next;
         logic                r_ready;
         logic [WIDTH-1:0]    r_main;
         logic [WIDTH-1:0]    r_skid;
         logic                w_src_hs;
         logic                w_dst_hs;

         assign w_src_hs = src_valid && r_ready;
         assign w_dst_hs = (r_state != TVIP_AXI_SLICE_EMPTY) && dst_ready;

         always_comb begin
            w_state_next = r_state;
            case (r_state)
               TVIP_AXI_SLICE_EMPTY: if (w_src_hs) w_state_next = TVIP_AXI_SLICE_ONE;
               TVIP_AXI_SLICE_ONE: begin
                  if (w_src_hs && !w_dst_hs)      w_state_next = TVIP_AXI_SLICE_TWO;
                  else if (!w_src_hs && w_dst_hs) w_state_next = TVIP_AXI_SLICE_EMPTY;
               end
               TVIP_AXI_SLICE_TWO:   if (w_dst_hs) w_state_next = TVIP_AXI_SLICE_ONE;
               default:              w_state_next = TVIP_AXI_SLICE_EMPTY;
            endcase
         end

         // Main always holds the oldest beat; skid only fills when main is stalled.
         always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n) begin
               r_state <= TVIP_AXI_SLICE_EMPTY;
               r_ready <= 1'b0;
               r_main  <= '0;
               r_skid  <= '0;
            end else begin
               r_state <= w_state_next;
               r_ready <= (w_state_next != TVIP_AXI_SLICE_TWO);
               case (r_state)
                  TVIP_AXI_SLICE_EMPTY: if (w_src_hs) r_main <= src_payload;
                  TVIP_AXI_SLICE_ONE: begin
                     if (w_src_hs && w_dst_hs) r_main <= src_payload;
                     else if (w_src_hs)        r_skid <= src_payload;
                  end
                  TVIP_AXI_SLICE_TWO:   if (w_dst_hs) r_main <= r_skid;
                  default: ;
               endcase
            end
         end

         assign src_ready   = r_ready;
         assign dst_valid   = (r_state != TVIP_AXI_SLICE_EMPTY);
         assign dst_payload = r_main;
      end
   endgenerate

endmodule

// File: rtl/tvip_axi_register_slice.sv
// AXI4 register slice: five independently configured channel slices; this level only packs payloads.
module tvip_axi_register_slice
   import tvip_axi_types_pkg::*;
#(
   parameter int ID_WIDTH      = 4,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int AW_MODE       = 2,
   parameter int W_MODE        = 2,
   parameter int B_MODE        = 2,
   parameter int AR_MODE       = 2,
   parameter int R_MODE        = 2
)(
   input  logic                      aclk,
   input  logic                      areset_n,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [ID_WIDTH-1:0]       s_awid,
   input  logic [ADDRESS_WIDTH-1:0]  s_awaddr,
   input  tvip_axi_burst_length      s_awlen,
   input  tvip_axi_burst_size        s_awsize,
   input  tvip_axi_burst_type        s_awburst,
   input  tvip_axi_qos               s_awqos,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wlast,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   output logic [ID_WIDTH-1:0]       s_bid,
   output tvip_axi_response          s_bresp,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   input  logic [ID_WIDTH-1:0]       s_arid,
   input  logic [ADDRESS_WIDTH-1:0]  s_araddr,
   input  tvip_axi_burst_length      s_arlen,
   input  tvip_axi_burst_size        s_arsize,
   input  tvip_axi_burst_type        s_arburst,
   input  tvip_axi_qos               s_arqos,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   output logic [ID_WIDTH-1:0]       s_rid,
   output logic [DATA_WIDTH-1:0]     s_rdata,
   output tvip_axi_response          s_rresp,
   output logic                      s_rlast,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [ID_WIDTH-1:0]       m_awid,
   output logic [ADDRESS_WIDTH-1:0]  m_awaddr,
   output tvip_axi_burst_length      m_awlen,
   output tvip_axi_burst_size        m_awsize,
   output tvip_axi_burst_type        m_awburst,
   output tvip_axi_qos               m_awqos,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   output logic [DATA_WIDTH-1:0]     m_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wlast,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   input  logic [ID_WIDTH-1:0]       m_bid,
   input  tvip_axi_response          m_bresp,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   output logic [ID_WIDTH-1:0]       m_arid,
   output logic [ADDRESS_WIDTH-1:0]  m_araddr,
   output tvip_axi_burst_length      m_arlen,
   output tvip_axi_burst_size        m_arsize,
   output tvip_axi_burst_type        m_arburst,
   output tvip_axi_qos               m_arqos,
   input  logic                      m_rvalid,
   output logic                      m_rready,
   input  logic [ID_WIDTH-1:0]       m_rid,
   input  logic [DATA_WIDTH-1:0]     m_rdata,
   input  tvip_axi_response          m_rresp,
   input  logic                      m_rlast
);

   localparam int AX_W = tvip_axi_addr_payload_width(ID_WIDTH, ADDRESS_WIDTH);
   localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8 + 1;
   localparam int B_W  = ID_WIDTH + TVIP_AXI_RESPONSE_WIDTH;
   localparam int R_W  = ID_WIDTH + DATA_WIDTH + TVIP_AXI_RESPONSE_WIDTH + 1;

   logic [AX_W-1:0] w_aw_payload;
   logic [W_W-1:0]  w_w_payload;
   logic [B_W-1:0]  w_b_payload;
   logic [AX_W-1:0] w_ar_payload;
   logic [R_W-1:0]  w_r_payload;

   tvip_axi_slice_channel #(.WIDTH(AX_W), .MODE(tvip_axi_slice_mode'(AW_MODE))) u_aw (
      .aclk(aclk), .areset_n(areset_n),
      .src_valid(s_awvalid), .src_ready(s_awready),
      .src_payload({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awqos}),
      .dst_valid(m_awvalid), .dst_ready(m_awready), .dst_payload(w_aw_payload)
   );
   assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awqos} = w_aw_payload;

   tvip_axi_slice_channel #(.WIDTH(W_W), .MODE(tvip_axi_slice_mode'(W_MODE))) u_w (
      .aclk(aclk), .areset_n(areset_n),
      .src_valid(s_wvalid), .src_ready(s_wready),
      .src_payload({s_wdata, s_wstrb, s_wlast}),
      .dst_valid(m_wvalid), .dst_ready(m_wready), .dst_payload(w_w_payload)
   );
   assign {m_wdata, m_wstrb, m_wlast} = w_w_payload;

   // Response channels run subordinate-to-manager.
   tvip_axi_slice_channel #(.WIDTH(B_W), .MODE(tvip_axi_slice_mode'(B_MODE))) u_b (
      .aclk(aclk), .areset_n(areset_n),
      .src_valid(m_bvalid), .src_ready(m_bready),
      .src_payload({m_bid, m_bresp}),
      .dst_valid(s_bvalid), .dst_ready(s_bready), .dst_payload(w_b_payload)
   );
   assign {s_bid, s_bresp} = w_b_payload;

   tvip_axi_slice_channel #(.WIDTH(AX_W), .MODE(tvip_axi_slice_mode'(AR_MODE))) u_ar (
      .aclk(aclk), .areset_n(areset_n),
      .src_valid(s_arvalid), .src_ready(s_arready),
      .src_payload({s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos}),
      .dst_valid(m_arvalid), .dst_ready(m_arready), .dst_payload(w_ar_payload)
   );
   assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos} = w_ar_payload;

   tvip_axi_slice_channel #(.WIDTH(R_W), .MODE(tvip_axi_slice_mode'(R_MODE))) u_r (
      .aclk(aclk), .areset_n(areset_n),
      .src_valid(m_rvalid), .src_ready(m_rready),
      .src_payload({m_rid, m_rdata, m_rresp, m_rlast}),
      .dst_valid(s_rvalid), .dst_ready(s_rready), .dst_payload(w_r_payload)
   );
   assign {s_rid, s_rdata, s_rresp, s_rlast} = w_r_payload;

endmodule
